mod_phasedetect: RTL

Recovers phase angle and magnitude from a signed sine/cosine sample pair using an iterative vectoring-mode CORDIC. It is the inverse of the sine source: the source maps time/period to an angle and then to a sine/cosine pair, and this block maps a pair back to an angle. It sits downstream of any sine/cosine producer, for example oscillator self-check, phase comparison between voices, or envelope/magnitude extraction. One sample is processed at a time, with a valid/ready pulse handshake.

---
 rtl/phasedetect_pkg.sv | 39 +++
 rtl/phasedetect_microrot.sv | 34 +++
 rtl/mod_phasedetect.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/phasedetect_pkg.sv
// Shared constants, FSM state type and arctangent table for the vectoring CORDIC phase detector.
package phasedetect_pkg;

    localparam int DW       = 20;
    localparam int MAX_ITER = 14;
    localparam logic [15:0] GAIN = 16'd19898;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREROT = 3'd1,
        ITER   = 3'd2,
        COMP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // atan(2^-i) scaled so that 32768 = pi
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] val;
        case (idx)
            4'd0:    val = 16'd8192;
            4'd1:    val = 16'd4836;
            4'd2:    val = 16'd2555;
            4'd3:    val = 16'd1297;
            4'd4:    val = 16'd651;
            4'd5:    val = 16'd326;
            4'd6:    val = 16'd163;
            4'd7:    val = 16'd81;
            4'd8:    val = 16'd41;
            4'd9:    val = 16'd20;
            4'd10:   val = 16'd10;
            4'd11:   val = 16'd5;
            4'd12:   val = 16'd3;
            4'd13:   val = 16'd1;
            default: val = 16'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/phasedetect_microrot.sv
// One combinational vectoring-mode CORDIC micro-rotation, driven towards y = 0.
module phasedetect_microrot
    import phasedetect_pkg::*;
(
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic        [15:0]   z,
    input  logic        [3:0]    i,
    output logic signed [DW-1:0] x_next,
    output logic signed [DW-1:0] y_next,
    output logic        [15:0]   z_next
);

    logic signed [DW-1:0] x_shift;
    logic signed [DW-1:0] y_shift;

    always_comb begin
        x_shift = x >>> i;
        y_shift = y >>> i;
        x_next  = x;
        y_next  = y;
        z_next  = z;
        if (!y[DW-1]) begin
            x_next = x + y_shift;
            y_next = y - x_shift;
            z_next = z + atan_lut(i);
        end else begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan_lut(i);
        end
    end

endmodule

// File: rtl/mod_phasedetect.sv
// atan2/magnitude recovery from a sine/cosine pair by iterative vectoring CORDIC.
// Define PHASEDETECT_GAINCOMP_EN to add the COMP state that removes the CORDIC gain from o_magnitude.
//   state  | meaning
//   IDLE   | waiting for i_valid, sample captured on strobe
//   PREROT | fold left half-plane vectors into the right half-plane
//   ITER   | one micro-rotation per cycle
//   COMP   | scale x by 1/K (gain compensation builds only)
//   DONE   | o_ready cycle, back to IDLE
module mod_phasedetect
    import phasedetect_pkg::*;
#(
    parameter int ITERATIONS = 14
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic signed [16:0] i_sine,
    input  logic signed [16:0] i_cosine,
    input  logic               i_valid,
    output logic signed [15:0] o_angle,
    output logic        [17:0] o_magnitude,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_overrun
);

    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

    state_t               state;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic        [15:0]   z;
    logic        [3:0]    i;
    logic                 zero;

    logic signed [DW-1:0] x_next;
    logic signed [DW-1:0] y_next;
    logic        [15:0]   z_next;

    phasedetect_microrot u_microrot (
        .x      (x),
        .y      (y),
        .z      (z),
        .i      (i),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

`ifdef PHASEDETECT_GAINCOMP_EN
    logic signed [DW+16:0] prod;
    logic        [17:0]    mag_comp;

    assign prod     = x * $signed({1'b0, GAIN});
    assign mag_comp = 18'(prod >>> 15);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            i           <= '0;
            zero        <= 1'b0;
            o_angle     <= '0;
            o_magnitude <= '0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_ready <= 1'b0;
            if (i_valid && state != IDLE)
                o_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x      <= {{(DW-17){i_cosine[16]}}, i_cosine};
                        y      <= {{(DW-17){i_sine[16]}}, i_sine};
                        o_busy <= 1'b1;
                        state  <= PREROT;
                    end
                end

                PREROT: begin
                    // (0,0) would otherwise sum the whole atan table
                    zero <= (x == '0) && (y == '0);
                    i    <= '0;
                    if (x[DW-1] && !y[DW-1]) begin
                        x <= y;
                        y <= -x;
                        z <= 16'h4000;
                    end else if (x[DW-1] && y[DW-1]) begin
                        x <= -y;
                        y <= x;
                        z <= 16'hC000;
                    end else begin
                        z <= '0;
                    end
                    state <= ITER;
                end

                ITER: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    i <= i + 4'd1;
                    if (i == LAST) begin
`ifdef PHASEDETECT_GAINCOMP_EN
                        state <= COMP;
`else
                        state       <= DONE;
                        o_ready     <= 1'b1;
                        o_angle     <= zero ? 16'sd0 : z_next;
                        o_magnitude <= x_next[17:0];
`endif
                    end
                end

`ifdef PHASEDETECT_GAINCOMP_EN
                COMP: begin
                    state       <= DONE;
                    o_ready     <= 1'b1;
                    o_angle     <= zero ? 16'sd0 : z;
                    o_magnitude <= mag_comp;
                end
`endif

                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
